// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: boot/run-mode round-robin arbiter for the single-port SRAM with tagged read return.
// Optional `SRAM_ARB_IMEM_WP_EN write-protects ch1 (instruction port) in run mode and flags wp_err.
module sram_port_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 20,
  parameter int NUM_CH     = 3,
  parameter int RD_LATENCY = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         boot_mode,
  input  logic [NUM_CH-1:0]            ch_req,
  input  logic [NUM_CH-1:0]            ch_wr,
  input  logic [NUM_CH*ADDR_WIDTH-1:0] ch_addr,
  input  logic [NUM_CH*DATA_WIDTH-1:0] ch_wr_data,
  output logic [NUM_CH-1:0]            ch_gnt,
  output logic [NUM_CH-1:0]            ch_rd_valid,
  output logic [DATA_WIDTH-1:0]        ch_rd_data,
  output logic                         sram_mem_wr_en,
  output logic                         sram_mem_rd_en,
  output logic [ADDR_WIDTH-1:0]        sram_mem_addr,
  output logic [DATA_WIDTH-1:0]        sram_mem_wr_data,
  input  logic [DATA_WIDTH-1:0]        sram_mem_rd_data,
  output logic                         wp_err
);
  localparam int IW = $clog2(NUM_CH);
  typedef enum logic {RUN, DRAIN} state_t;
  state_t state;
  logic mode_q, grant_ok, found, g_any, g_wr, wp_block, pipe_empty;
  logic [IW-1:0] rr, gidx;
  logic [NUM_CH-1:0] iss_tag;
  logic [NUM_CH-1:0] tag_pipe [RD_LATENCY];
  logic [ADDR_WIDTH-1:0] g_addr;
  logic [DATA_WIDTH-1:0] g_data;
  always_comb begin
    int c;
    c = 0;
    grant_ok = rst_n && state == RUN && boot_mode == mode_q;
    ch_gnt = '0;
    found = 1'b0;
    if (grant_ok && mode_q) ch_gnt[0] = ch_req[0];
    else if (grant_ok)
      for (int k = 1; k < NUM_CH; k++) begin
        c = (int'(rr) + k > NUM_CH - 1) ? int'(rr) + k - (NUM_CH - 1) : int'(rr) + k;
        if (!found && ch_req[IW'(c)]) begin
          ch_gnt[IW'(c)] = 1'b1;
          found = 1'b1;
        end
      end
    g_any = |ch_gnt;
    gidx = '0;
    g_wr = 1'b0;
    g_addr = '0;
    g_data = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (ch_gnt[i]) begin
        gidx = IW'(i);
        g_wr = ch_wr[i];
        g_addr = ch_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        g_data = ch_wr_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    pipe_empty = iss_tag == '0;
    for (int i = 0; i < RD_LATENCY; i++) pipe_empty = pipe_empty && tag_pipe[i] == '0;
  end
`ifdef SRAM_ARB_IMEM_WP_EN
  assign wp_block = !mode_q && ch_gnt[1] && ch_wr[1];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) wp_err <= 1'b0;
    else wp_err <= wp_err | wp_block;
`else
  assign wp_block = 1'b0;
  assign wp_err = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= RUN;
      mode_q <= 1'b0;
      rr <= '0;
      sram_mem_wr_en <= 1'b0;
      sram_mem_rd_en <= 1'b0;
      sram_mem_addr <= '0;
      sram_mem_wr_data <= '0;
      iss_tag <= '0;
      for (int i = 0; i < RD_LATENCY; i++) tag_pipe[i] <= '0;
      ch_rd_valid <= '0;
      ch_rd_data <= '0;
    end else begin
      if (state == RUN && boot_mode != mode_q) state <= DRAIN;
      else if (state == DRAIN && pipe_empty) begin
        state <= RUN;
        mode_q <= boot_mode;
      end
      rr <= (g_any && !mode_q) ? gidx : rr;
      sram_mem_wr_en <= g_any && g_wr && !wp_block;
      sram_mem_rd_en <= g_any && !g_wr;
      sram_mem_addr <= g_any ? g_addr : sram_mem_addr;
      sram_mem_wr_data <= g_any ? g_data : sram_mem_wr_data;
      // tag follows the read through the SRAM latency so data returns to its issuer
      iss_tag <= (g_any && !g_wr) ? ch_gnt : '0;
      tag_pipe[0] <= iss_tag;
      for (int i = 1; i < RD_LATENCY; i++) tag_pipe[i] <= tag_pipe[i-1];
      ch_rd_valid <= tag_pipe[RD_LATENCY-1];
      ch_rd_data <= |tag_pipe[RD_LATENCY-1] ? sram_mem_rd_data : ch_rd_data;
    end
endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: table-driven grant/command vectors plus hand sequences for read latency, mode drain and async reset.
module tb_sram_port_arbiter;
`ifdef SRAM_ARB_IMEM_WP_EN
  localparam bit WP = 1'b1;
`else
  localparam bit WP = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0, boot_mode = 1'b0;
  logic [2:0] ch_req = '0, ch_wr = '0, ch_gnt, ch_rd_valid;
  logic [59:0] ch_addr = {20'h00004, 20'h00020, 20'h00010};
  logic [95:0] ch_wr_data = {32'h22222222, 32'h11111111, 32'hDEADBEEF};
  logic [31:0] ch_rd_data, sram_mem_wr_data, sram_mem_rd_data, rd_p1 = '0, rd_p2 = '0;
  logic [19:0] sram_mem_addr;
  logic sram_mem_wr_en, sram_mem_rd_en, wp_err;
  int n_chk = 0, n_fail = 0;

  sram_port_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(20), .NUM_CH(3), .RD_LATENCY(2)) dut (
    .clk(clk), .rst_n(rst_n), .boot_mode(boot_mode), .ch_req(ch_req), .ch_wr(ch_wr),
    .ch_addr(ch_addr), .ch_wr_data(ch_wr_data), .ch_gnt(ch_gnt), .ch_rd_valid(ch_rd_valid),
    .ch_rd_data(ch_rd_data), .sram_mem_wr_en(sram_mem_wr_en), .sram_mem_rd_en(sram_mem_rd_en),
    .sram_mem_addr(sram_mem_addr), .sram_mem_wr_data(sram_mem_wr_data),
    .sram_mem_rd_data(sram_mem_rd_data), .wp_err(wp_err));

  always #5 clk = ~clk;

  // two-cycle SRAM model; address 4 holds the test-plan word, others a tagged pattern
  always @(posedge clk) begin
    rd_p1 <= sram_mem_rd_en ? ((sram_mem_addr == 20'h4) ? 32'h12345678 : {12'hA5A, sram_mem_addr}) : 32'h0;
    rd_p2 <= rd_p1;
  end
  assign sram_mem_rd_data = rd_p2;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic bm, input logic [2:0] req, input logic [2:0] wr);
    boot_mode = bm;
    ch_req = req;
    ch_wr = wr;
  endtask

  typedef struct {
    logic bm; logic [2:0] req; logic [2:0] wr; logic [2:0] gnt;
    logic rd; logic we; logic [19:0] addr; logic [31:0] wd;
  } vec_t;
  vec_t tv[16];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int waited, pulses;
    logic [31:0] last_data;
    tv[0]  = '{1'b0, 3'b110, 3'b000, 3'b010, 1'b1, 1'b0, 20'h00020, 32'h11111111};
    tv[1]  = '{1'b0, 3'b110, 3'b000, 3'b100, 1'b1, 1'b0, 20'h00004, 32'h22222222};
    tv[2]  = '{1'b0, 3'b110, 3'b000, 3'b010, 1'b1, 1'b0, 20'h00020, 32'h11111111};
    tv[3]  = '{1'b0, 3'b110, 3'b000, 3'b100, 1'b1, 1'b0, 20'h00004, 32'h22222222};
    tv[4]  = '{1'b0, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 20'h00004, 32'h22222222};
    tv[5]  = '{1'b0, 3'b001, 3'b001, 3'b000, 1'b0, 1'b0, 20'h00004, 32'h22222222};
    tv[6]  = '{1'b0, 3'b101, 3'b100, 3'b100, 1'b0, 1'b1, 20'h00004, 32'h22222222};
    tv[7]  = '{1'b0, 3'b010, 3'b010, 3'b010, 1'b0, !WP,  20'h00020, 32'h11111111};
    tv[8]  = '{1'b1, 3'b011, 3'b001, 3'b000, 1'b0, 1'b0, 20'h00020, 32'h11111111};
    tv[9]  = '{1'b1, 3'b011, 3'b001, 3'b000, 1'b0, 1'b0, 20'h00020, 32'h11111111};
    tv[10] = '{1'b1, 3'b011, 3'b001, 3'b001, 1'b0, 1'b1, 20'h00010, 32'hDEADBEEF};
    tv[11] = '{1'b1, 3'b010, 3'b000, 3'b000, 1'b0, 1'b0, 20'h00010, 32'hDEADBEEF};
    tv[12] = '{1'b0, 3'b110, 3'b000, 3'b000, 1'b0, 1'b0, 20'h00010, 32'hDEADBEEF};
    tv[13] = '{1'b0, 3'b110, 3'b000, 3'b000, 1'b0, 1'b0, 20'h00010, 32'hDEADBEEF};
    tv[14] = '{1'b0, 3'b110, 3'b000, 3'b100, 1'b1, 1'b0, 20'h00004, 32'h22222222};
    tv[15] = '{1'b0, 3'b110, 3'b000, 3'b010, 1'b1, 1'b0, 20'h00020, 32'h11111111};
    #1;
    chk("rst_ctrl", {ch_gnt, ch_rd_valid, sram_mem_wr_en, sram_mem_rd_en, wp_err}, 9'h0);
    chk("rst_addr", sram_mem_addr, 20'h0);
    chk("rst_wdata", sram_mem_wr_data, 32'h0);
    chk("rst_rdata", ch_rd_data, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    for (int v = 0; v < 16; v++) begin
      drive(tv[v].bm, tv[v].req, tv[v].wr);
      @(negedge clk);
      chk($sformatf("v%0d_gnt", v), ch_gnt, tv[v].gnt);
      @(posedge clk); #1;
      chk($sformatf("v%0d_rd_en", v), sram_mem_rd_en, tv[v].rd);
      chk($sformatf("v%0d_wr_en", v), sram_mem_wr_en, tv[v].we);
      chk($sformatf("v%0d_addr", v), sram_mem_addr, tv[v].addr);
      chk($sformatf("v%0d_wdata", v), sram_mem_wr_data, tv[v].wd);
    end
    drive(1'b0, 3'b000, 3'b000);
    repeat (6) @(posedge clk);
    #1;
    // read return: valid exactly RD_LATENCY+1 cycles after rd_en
    drive(1'b0, 3'b100, 3'b000);
    @(negedge clk) chk("lat_gnt", ch_gnt, 3'b100);
    @(posedge clk); #1;
    chk("lat_rd_en", {sram_mem_rd_en, ch_rd_valid}, 4'b1000);
    chk("lat_addr", sram_mem_addr, 20'h4);
    drive(1'b0, 3'b000, 3'b000);
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      chk($sformatf("lat_valid_c%0d", k), ch_rd_valid, (k == 3) ? 3'b100 : 3'b000);
    end
    chk("lat_data", ch_rd_data, 32'h12345678);
    @(posedge clk); #1;
    chk("lat_pulse_end", ch_rd_valid, 3'b000);
    // mode switch with two ch1 reads in flight
    drive(1'b0, 3'b010, 3'b000);
    @(negedge clk) chk("drain_g1", ch_gnt, 3'b010);
    @(posedge clk); #1;
    @(negedge clk) chk("drain_g2", ch_gnt, 3'b010);
    @(posedge clk); #1;
    drive(1'b1, 3'b011, 3'b000);
    waited = 0;
    pulses = 0;
    last_data = '0;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      if (ch_gnt != 3'b000) break;
      waited++;
      if (ch_rd_valid == 3'b010) begin
        pulses++;
        last_data = ch_rd_data;
      end
      @(posedge clk); #1;
    end
    chk("drain_gnt", ch_gnt, 3'b001);
    chk("drain_wait", waited, 4);
    chk("drain_pulses", pulses, 2);
    chk("drain_data", last_data, 32'hA5A00020);
    @(posedge clk); #1;
    chk("drain_cmd", {sram_mem_rd_en, sram_mem_wr_en, sram_mem_addr}, {2'b10, 20'h00010});
    chk("wp_err_sticky", wp_err, WP);
    // async reset with a boot read in flight
    drive(1'b1, 3'b001, 3'b000);
    @(negedge clk) chk("arst_gnt", ch_gnt, 3'b001);
    @(posedge clk); #1;
    chk("arst_rd_en", sram_mem_rd_en, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ctrl", {ch_gnt, ch_rd_valid, sram_mem_wr_en, sram_mem_rd_en, wp_err}, 9'h0);
    chk("arst_addr", sram_mem_addr, 20'h0);
    chk("arst_wdata", sram_mem_wr_data, 32'h0);
    chk("arst_rdata", ch_rd_data, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    drive(1'b1, 3'b000, 3'b000);
    pulses = 0;
    repeat (8) begin
      @(negedge clk);
      if (ch_rd_valid != 3'b000) pulses++;
    end
    chk("arst_no_valid", pulses, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
Multi-channel arbiter in front of the single-port instruction/data SRAM, replacing the combinational boot/DLX mux. Channel 0 is the bootloader; channels 1..NUM_CH-1 are DLX ports (instruction, data, ...). Requests are accepted with a one-cycle grant handshake and issued as registered SRAM commands. Read data is returned to the issuing channel through a latency-matched tag pipeline.

Parameters:
DATA_WIDTH, 32, SRAM data width
ADDR_WIDTH, 20, SRAM word address width
NUM_CH, 3, number of channels (min 2); ch0 = boot
RD_LATENCY, 1, cycles from registered sram_mem_rd_en to valid sram_mem_rd_data (1..4)

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
boot_mode  input  1  1 = only ch0 eligible; 0 = only ch1..NUM_CH-1 eligible
ch_req  input  NUM_CH  per-channel request, held until granted
ch_wr  input  NUM_CH  1 = write, 0 = read; qualified by ch_req
ch_addr  input  NUM_CH*ADDR_WIDTH  packed addresses, ch i at [i*ADDR_WIDTH +: ADDR_WIDTH]
ch_wr_data  input  NUM_CH*DATA_WIDTH  packed write data
ch_gnt  output  NUM_CH  one-hot combinational grant; request accepted this cycle
ch_rd_valid  output  NUM_CH  one-hot registered pulse, read data for that channel
ch_rd_data  output  DATA_WIDTH  shared read data, valid with ch_rd_valid
sram_mem_wr_en  output  1  registered SRAM write enable
sram_mem_rd_en  output  1  registered SRAM read enable
sram_mem_addr  output  ADDR_WIDTH  registered SRAM address
sram_mem_wr_data  output  DATA_WIDTH  registered SRAM write data
sram_mem_rd_data  input  DATA_WIDTH  SRAM read data
wp_err  output  1  sticky write-protect violation (see Optional Feature)

Behaviour:
- Reset: all registered outputs 0, ch_rd_valid 0, ch_rd_data 0, tag pipeline empty, rr pointer = 0, state RUN, wp_err 0. Reset mid-read discards outstanding reads (no ch_rd_valid after release).
- States: RUN, DRAIN. RUN: at most one grant per cycle; back-to-back grants allowed (full throughput).
- boot_mode sampled in a register; when the input differs from the registered value -> DRAIN, no grants. DRAIN -> RUN (registered mode updated) when tag pipeline empty; ch_gnt may assert again in that RUN cycle.
- Eligibility: boot mode = ch0 only; run mode = ch1..NUM_CH-1, round-robin starting from rr pointer+1, wrapping past NUM_CH-1 to 1; ch0 ignored. rr pointer <= granted channel on each run-mode grant; unchanged in boot mode.
- Grant cycle N: ch_gnt[i]=1; cycle N+1: sram_mem_* reflect ch i (rd_en = !ch_wr[i], wr_en = ch_wr[i]); both 0 when no grant. addr/wr_data hold last value when idle.
- Read tag: one-hot channel shifted RD_LATENCY stages after rd_en; ch_rd_valid/ch_rd_data registered from the stage output, i.e. valid RD_LATENCY+1 cycles after sram_mem_rd_en.
- Writes produce no ch_rd_valid. Requester deasserting ch_req without a grant is legal; no state change.

Optional Feature:
Macro SRAM_ARB_IMEM_WP_EN. Defined: in run mode a ch1 (instruction port) write is granted (consumed) but sram_mem_wr_en stays 0 and wp_err sets, sticky until reset. Undefined: ch1 writes issue normally; wp_err tied 0.

Test Plan:
- Boot write: boot_mode=1, ch0 req wr addr 0x00010 data 0xDEADBEEF -> ch_gnt=001 cycle N, sram_mem_wr_en=1 addr 0x00010 data 0xDEADBEEF cycle N+1; ch1 req held ignored.
- Round robin: boot_mode=0, ch1 and ch2 req reads continuously -> grants 010,100,010,100; sram_mem_rd_en high every cycle.
- Read return, RD_LATENCY=2: ch2 read addr 0x00004, SRAM returns 0x12345678 -> ch_rd_valid=100, ch_rd_data=0x12345678, exactly 3 cycles after sram_mem_rd_en.
- Mode switch with reads in flight: two ch1 reads issued, boot_mode 0->1 -> both ch_rd_valid=010 delivered, no grant until pipeline empty, then ch0 granted.
- Async reset mid-read: rst_n low while read in flight -> all outputs 0 immediately, no ch_rd_valid after release.
- SRAM_ARB_IMEM_WP_EN defined: run-mode ch1 write -> ch_gnt=010, sram_mem_wr_en stays 0, wp_err=1 until reset; undefined -> write issued, wp_err=0.
